// File: rtl/dma_ctrl_pkg.sv
// Shared types and constants for the rotate-job DMA sequencer.
package dma_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdXfer,
    StCoreRun,
    StWrReq,
    StWrXfer
  } dctl_state_e;

  localparam logic [2:0]  SIZE_WORD      = 3'b010;
  localparam int unsigned BYTES_PER_WORD = 4;

  function automatic logic [15:0] min_chunk(input logic [15:0] rem,
                                            input int unsigned max_burst);
    return (rem < 16'(max_burst)) ? rem : 16'(max_burst);
  endfunction

endpackage

// File: rtl/dctl_beat_cnt.sv
// Per-chunk beat counter: drives the buffer beat pointer and flags the final beat of a chunk.
module dctl_beat_cnt #(
  parameter int unsigned PTR_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [PTR_W-1:0] len_i,
  output logic [PTR_W-1:0] ptr_o,
  output logic             last_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Terminal count is decoded from the beat in flight, so it is valid in the same cycle.
  assign last_o = inc_i && ((ptr_q + PTR_W'(1)) == len_i);
  assign ptr_o  = ptr_q;

endmodule

// File: rtl/dma_ctrl.sv
// Rotate-job sequencer: splits a job into bursts of at most MAX_BURST words and runs
// read burst -> rotate core -> write burst for each chunk.
module dma_ctrl
  import dma_ctrl_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned PTR_W     = 8
) (
  input  logic             I_DCTL_HCLK,
  input  logic             I_DCTL_RESET,
  input  logic             I_DCTL_GO,
  input  logic [31:0]      I_DCTL_SRC_ADDR,
  input  logic [31:0]      I_DCTL_DST_ADDR,
  input  logic [15:0]      I_DCTL_WORDS,
  input  logic             I_DCTL_ABORT,
  input  logic             I_DCTL_BEAT,
  input  logic             I_DCTL_CORE_DONE,
  output logic             O_DCTL_DMA_START,
  output logic [31:0]      O_DCTL_DMA_ADDR,
  output logic [4:0]       O_DCTL_DMA_COUNT,
  output logic [2:0]       O_DCTL_DMA_SIZE,
  output logic             O_DCTL_DMA_WRITE,
  output logic             O_DCTL_DMA_RESET,
  output logic [PTR_W-1:0] O_DCTL_BUF_PTR,
  output logic             O_DCTL_CORE_START,
  output logic             O_DCTL_BUSY,
  output logic             O_DCTL_DONE,
  output logic             O_DCTL_ABORTED
);

  dctl_state_e state_q, state_d;
  logic [15:0] rem_q, rem_d, rem_next;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] chunk_q, chunk_d, chunk_now;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        dma_rst_q, dma_rst_d;
  logic        core_start_q, core_start_d;
  logic        cnt_load, cnt_inc, cnt_last;
  logic        in_req, in_xfer;

  assign chunk_now = min_chunk(rem_q, MAX_BURST);
  assign in_req    = (state_q == StRdReq) || (state_q == StWrReq);
  assign in_xfer   = (state_q == StRdXfer) || (state_q == StWrXfer);

  // The pointer is cleared as a REQ state is entered so it already reads 0 during REQ.
  assign cnt_load = I_DCTL_ABORT || (state_d == StRdReq) || (state_d == StWrReq);
  assign cnt_inc  = I_DCTL_BEAT && !I_DCTL_ABORT && in_xfer;

  dctl_beat_cnt #(
    .PTR_W(PTR_W)
  ) u_beat_cnt (
    .clk_i (I_DCTL_HCLK),
    .rst_i (I_DCTL_RESET),
    .load_i(cnt_load),
    .inc_i (cnt_inc),
    .len_i (PTR_W'(chunk_q)),
    .ptr_o (O_DCTL_BUF_PTR),
    .last_o(cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    src_d        = src_q;
    dst_d        = dst_q;
    chunk_d      = chunk_q;
    addr_d       = addr_q;
    write_d      = write_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    dma_rst_d    = 1'b0;
    core_start_d = 1'b0;
    rem_next     = rem_q - chunk_q;

    if (I_DCTL_ABORT) begin
      state_d   = StIdle;
      dma_rst_d = 1'b1;
      aborted_d = (state_q != StIdle);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (I_DCTL_GO) begin
            if (I_DCTL_WORDS == 16'd0) begin
              done_d = 1'b1;
            end else begin
              rem_d   = I_DCTL_WORDS;
              src_d   = I_DCTL_SRC_ADDR;
              dst_d   = I_DCTL_DST_ADDR;
              state_d = StRdReq;
            end
          end
        end
        StRdReq: begin
          addr_d  = src_q;
          chunk_d = chunk_now;
          write_d = 1'b0;
          state_d = StRdXfer;
        end
        StRdXfer: begin
          if (cnt_last) begin
            core_start_d = 1'b1;
            state_d      = StCoreRun;
          end
        end
        StCoreRun: begin
          // A done flag overlapping the start pulse belongs to a previous run.
          if (I_DCTL_CORE_DONE && !core_start_q) begin
            state_d = StWrReq;
          end
        end
        StWrReq: begin
          addr_d  = dst_q;
          chunk_d = chunk_now;
          write_d = 1'b1;
          state_d = StWrXfer;
        end
        StWrXfer: begin
          if (cnt_last) begin
            rem_d = rem_next;
            src_d = src_q + 32'(chunk_q) * BYTES_PER_WORD;
            dst_d = dst_q + 32'(chunk_q) * BYTES_PER_WORD;
            if (rem_next == 16'd0) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StRdReq;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge I_DCTL_HCLK or posedge I_DCTL_RESET) begin
    if (I_DCTL_RESET) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      chunk_q      <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      dma_rst_q    <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      chunk_q      <= chunk_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      dma_rst_q    <= dma_rst_d;
      core_start_q <= core_start_d;
    end
  end

  // Command fields are live during REQ and then held from the registers until the next REQ.
  always_comb begin
    O_DCTL_DMA_ADDR  = addr_q;
    O_DCTL_DMA_COUNT = chunk_q[4:0];
    O_DCTL_DMA_WRITE = write_q;
    if (state_q == StRdReq) begin
      O_DCTL_DMA_ADDR  = src_q;
      O_DCTL_DMA_COUNT = chunk_now[4:0];
      O_DCTL_DMA_WRITE = 1'b0;
    end else if (state_q == StWrReq) begin
      O_DCTL_DMA_ADDR  = dst_q;
      O_DCTL_DMA_COUNT = chunk_now[4:0];
      O_DCTL_DMA_WRITE = 1'b1;
    end
  end

  assign O_DCTL_DMA_START  = in_req;
  assign O_DCTL_DMA_SIZE   = SIZE_WORD;
  assign O_DCTL_DMA_RESET  = dma_rst_q;
  assign O_DCTL_CORE_START = core_start_q;
  assign O_DCTL_BUSY       = (state_q != StIdle);
  assign O_DCTL_DONE       = done_q;
  assign O_DCTL_ABORTED    = aborted_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: a burst scoreboard checks every DMA request as it appears.
module tb_dma_ctrl;

  localparam int MAXB = 16;
  localparam int PW   = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  cnt;
    logic        wr;
  } burst_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go_i = 1'b0;
  logic [31:0]   src_i = '0;
  logic [31:0]   dst_i = '0;
  logic [15:0]   words_i = '0;
  logic          abort_i = 1'b0;
  logic          beat_i = 1'b0;
  logic          cdone_i = 1'b0;
  logic          dma_start, dma_write, dma_reset, core_start, busy, done, aborted;
  logic [31:0]   dma_addr;
  logic [4:0]    dma_count;
  logic [2:0]    dma_size;
  logic [PW-1:0] buf_ptr;

  int     checks = 0;
  int     failures = 0;
  burst_t sb[$];

  dma_ctrl #(
    .MAX_BURST(MAXB),
    .PTR_W    (PW)
  ) dut (
    .I_DCTL_HCLK      (clk),
    .I_DCTL_RESET     (rst),
    .I_DCTL_GO        (go_i),
    .I_DCTL_SRC_ADDR  (src_i),
    .I_DCTL_DST_ADDR  (dst_i),
    .I_DCTL_WORDS     (words_i),
    .I_DCTL_ABORT     (abort_i),
    .I_DCTL_BEAT      (beat_i),
    .I_DCTL_CORE_DONE (cdone_i),
    .O_DCTL_DMA_START (dma_start),
    .O_DCTL_DMA_ADDR  (dma_addr),
    .O_DCTL_DMA_COUNT (dma_count),
    .O_DCTL_DMA_SIZE  (dma_size),
    .O_DCTL_DMA_WRITE (dma_write),
    .O_DCTL_DMA_RESET (dma_reset),
    .O_DCTL_BUF_PTR   (buf_ptr),
    .O_DCTL_CORE_START(core_start),
    .O_DCTL_BUSY      (busy),
    .O_DCTL_DONE      (done),
    .O_DCTL_ABORTED   (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every DMA request must match the next expected burst.
  always @(negedge clk) begin
    if (!rst && dma_start === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_start", 32'(dma_start), 32'd0);
      end else begin
        burst_t e;
        e = sb.pop_front();
        chk("burst_addr", dma_addr, e.addr);
        chk("burst_count", 32'(dma_count), 32'(e.cnt));
        chk("burst_write", 32'(dma_write), 32'(e.wr));
      end
    end
  end

  task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] w);
    int unsigned r;
    logic [31:0] off;
    r = w;
    off = '0;
    while (r > 0) begin
      int unsigned c;
      c = (r < MAXB) ? r : MAXB;
      sb.push_back('{addr: s + off, cnt: 5'(c), wr: 1'b0});
      sb.push_back('{addr: d + off, cnt: 5'(c), wr: 1'b1});
      off = off + 32'(c * 4);
      r = r - c;
    end
    src_i = s;
    dst_i = d;
    words_i = w;
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (dma_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(dma_start), 32'd1);
    chk("req_ptr_zero", 32'(buf_ptr), 32'd0);
  endtask

  task automatic beats(input int n, input int gap, input int exp_cnt);
    for (int i = 0; i < n; i++) begin
      chk("buf_ptr", 32'(buf_ptr), 32'(i));
      if (i == n - 1) chk("count_hold", 32'(dma_count), 32'(exp_cnt));
      beat_i = 1'b1;
      tick();
      beat_i = 1'b0;
      if (i < n - 1) repeat (gap) tick();
    end
  endtask

  task automatic core(input int dly, input bit spurious, input int c);
    chk("core_start", 32'(core_start), 32'd1);
    cdone_i = 1'b1;
    tick();
    cdone_i = 1'b0;
    chk("core_start_1cyc", 32'(core_start), 32'd0);
    chk("coincident_done_ignored", 32'(dma_start), 32'd0);
    beat_i = spurious;
    tick();
    beat_i = 1'b0;
    chk("spurious_beat_ptr", 32'(buf_ptr), 32'(c));
    chk("core_wait_busy", 32'(busy), 32'd1);
    chk("core_wait_no_start", 32'(dma_start), 32'd0);
    repeat (dly - 2) tick();
    cdone_i = 1'b1;
    tick();
    cdone_i = 1'b0;
  endtask

  task automatic do_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] w,
                        input int gap, input int dly, input bit spurious);
    int r;
    int c;
    go(s, d, w);
    chk("go_latency", 32'(dma_start), 32'd1);
    r = w;
    while (r > 0) begin
      c = (r < MAXB) ? r : MAXB;
      wait_start("rd_start");
      tick();
      beats(c, gap, c);
      core(dly, spurious, c);
      wait_start("wr_start");
      tick();
      beats(c, gap, c);
      r = r - c;
      if (r == 0) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_fall", 32'(busy), 32'd0);
        tick();
        chk("done_1cyc", 32'(done), 32'd0);
      end else begin
        chk("no_early_done", 32'(done), 32'd0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(dma_start), 32'd0);
    chk("rst_size", 32'(dma_size), 32'h2);
    chk("rst_addr", dma_addr, 32'd0);
    chk("rst_ptr", 32'(buf_ptr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Single chunk, back-to-back beats.
    do_job(32'h1000, 32'h2000, 16'd8, 0, 5, 1'b0);
    // Three chunks: 16, 16, 8.
    do_job(32'h1000, 32'h2000, 16'd40, 0, 5, 1'b0);

    // Zero-length job.
    go(32'h1000, 32'h2000, 16'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_start", 32'(dma_start), 32'd0);
    tick();
    chk("zero_done_1cyc", 32'(done), 32'd0);
    chk("zero_busy2", 32'(busy), 32'd0);

    // Stalled beats with a stray beat during the core run.
    do_job(32'h1100, 32'h2100, 16'd8, 3, 5, 1'b1);
    // Address wrap across 2^32.
    do_job(32'hFFFF_FFC0, 32'hFFFF_FF00, 16'd20, 0, 3, 1'b0);

    // Abort after three beats of a sixteen-beat read.
    go(32'h3000, 32'h4000, 16'd16);
    void'(sb.pop_back());
    wait_start("abort_rd_start");
    tick();
    beats(3, 0, 16);
    chk("abort_pre_ptr", 32'(buf_ptr), 32'd3);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_dma_reset", 32'(dma_reset), 32'd1);
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    tick();
    chk("abort_dma_reset_1cyc", 32'(dma_reset), 32'd0);
    chk("abort_pulse_1cyc", 32'(aborted), 32'd0);
    do_job(32'h5000, 32'h6000, 16'd4, 0, 4, 1'b0);

    // Abort while idle only resets the DMA engine.
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("idle_abort_reset", 32'(dma_reset), 32'd1);
    chk("idle_abort_no_pulse", 32'(aborted), 32'd0);
    tick();

    // Asynchronous reset in the middle of a write burst.
    go(32'h7000, 32'h8000, 16'd8);
    wait_start("rst_rd_start");
    tick();
    beats(8, 0, 8);
    core(3, 1'b0, 8);
    wait_start("rst_wr_start");
    tick();
    beat_i = 1'b1;
    tick();
    tick();
    beat_i = 1'b0;
    chk("pre_rst_ptr", 32'(buf_ptr), 32'd2);
    #2;
    rst = 1'b1;
    go_i = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ptr", 32'(buf_ptr), 32'd0);
    chk("async_rst_addr", dma_addr, 32'd0);
    chk("async_rst_write", 32'(dma_write), 32'd0);
    chk("async_rst_size", 32'(dma_size), 32'h2);
    repeat (2) tick();
    go_i = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_start", 32'(dma_start), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
- Job sequencer for the dma block. Takes one rotate job (source base, destination base, word count) and splits it into chunks of at most MAX_BURST words.
- For each chunk it issues an AHB read burst into the input pixel buffer, starts the rotate core and waits for it to finish, then issues an AHB write burst from the output pixel buffer.
- It drives the dma command inputs (start, addr, count, size, write, soft reset) and a per-beat buffer pointer. Top level decodes that pointer into the buffer byte-lane addresses.

Parameters:
- MAX_BURST, 16, maximum words per chunk. Legal range 1..16, because dma count is 5 bits.
- PTR_W, 8, width of the buffer beat pointer.

Ports:
- I_DCTL_HCLK  in  1  system clock; all state updates on the rising edge.
- I_DCTL_RESET  in  1  asynchronous, active-high reset.
- I_DCTL_GO  in  1  one-cycle job start pulse; sampled in IDLE only.
- I_DCTL_SRC_ADDR  in  32  source byte address, word aligned.
- I_DCTL_DST_ADDR  in  32  destination byte address, word aligned.
- I_DCTL_WORDS  in  16  job length in 32-bit words.
- I_DCTL_ABORT  in  1  cancels the job from any state.
- I_DCTL_BEAT  in  1  one pulse per completed AHB data beat (HREADY during a data phase), generated at top level.
- I_DCTL_CORE_DONE  in  1  rotate core has finished the current chunk.
- O_DCTL_DMA_START  out  1  one-cycle burst request to dma.
- O_DCTL_DMA_ADDR  out  32  burst start address.
- O_DCTL_DMA_COUNT  out  5  beats in this burst.
- O_DCTL_DMA_SIZE  out  3  constant 3'b010 (word).
- O_DCTL_DMA_WRITE  out  1  0 = read burst, 1 = write burst.
- O_DCTL_DMA_RESET  out  1  one-cycle soft reset to dma on abort.
- O_DCTL_BUF_PTR  out  PTR_W  beat index within the current chunk.
- O_DCTL_CORE_START  out  1  one-cycle rotate core start.
- O_DCTL_BUSY  out  1  high whenever the FSM is not in IDLE.
- O_DCTL_DONE  out  1  one-cycle pulse when the job completes.
- O_DCTL_ABORTED  out  1  one-cycle pulse when an abort is taken.

Behaviour:
- Reset: all outputs 0 except DMA_SIZE (3'b010). FSM goes to IDLE; rem, src_ptr, dst_ptr, chunk and BUF_PTR are cleared.
- Chunk size: chunk = min(rem, MAX_BURST), computed in the REQ states. DMA_COUNT = chunk[4:0].
- IDLE:
  - GO with WORDS=0 pulses DONE on the next cycle and stays in IDLE. No DMA activity.
  - GO with WORDS>0 latches rem=WORDS, src_ptr=SRC_ADDR, dst_ptr=DST_ADDR, then moves to RD_REQ.
- GO outside IDLE is ignored.
- RD_REQ (1 cycle): START=1, ADDR=src_ptr, WRITE=0, BUF_PTR=0. Next state RD_XFER.
- RD_XFER:
  - Each BEAT increments BUF_PTR.
  - The BEAT that brings the beat count to chunk moves the FSM to CORE_RUN and asserts CORE_START for exactly 1 cycle on entry.
- CORE_RUN: waits for CORE_DONE, then moves to WR_REQ.
  - CORE_DONE is accepted from the cycle after CORE_START onward.
  - CORE_DONE coincident with CORE_START is ignored.
- WR_REQ (1 cycle): START=1, ADDR=dst_ptr, WRITE=1, BUF_PTR=0. Next state WR_XFER.
- WR_XFER: the last BEAT updates rem -= chunk, src_ptr += chunk*4 and dst_ptr += chunk*4. Then:
  - new rem=0: go to IDLE with DONE pulsed in that cycle;
  - otherwise: go to RD_REQ.
- DMA_ADDR, COUNT and WRITE hold their values from REQ until the next REQ, so they are stable through XFER.
- BEAT outside the XFER states is ignored.
- Address wrap: 32-bit addresses wrap modulo 2^32 with no error.
- Abort:
  - Has priority over every other event in the same cycle.
  - Next state is IDLE. DMA_RESET and ABORTED are each pulsed for 1 cycle.
  - DONE is not pulsed, and a CORE_START due in the same cycle is suppressed.
  - ABORT in IDLE pulses only DMA_RESET.
- Throughput: per chunk, 1 REQ cycle + chunk beats + core time + 1 REQ cycle + chunk beats.
- Latency: GO to first START is 1 cycle.

Decomposition:
- Package dma_ctrl_pkg holds:
  - FSM state encoding: IDLE, RD_REQ, RD_XFER, CORE_RUN, WR_REQ, WR_XFER;
  - SIZE_WORD = 3'b010;
  - BYTES_PER_WORD = 4.
- One natural sub-module, dctl_beat_cnt: the beat counter with a terminal-count flag. It is loaded in the REQ states, increments on BEAT, drives BUF_PTR and the last-beat flag.
- The FSM and the job registers stay in dma_ctrl.

Test Plan:
- WORDS=8, SRC=0x1000, DST=0x2000, 1 beat per cycle, CORE_DONE 5 cycles after CORE_START -> one read burst (ADDR 0x1000, COUNT 8, WRITE 0), one CORE_START, one write burst (ADDR 0x2000, COUNT 8, WRITE 1), then a DONE pulse with BUSY falling.
- WORDS=40, MAX_BURST=16 -> chunks of 16, 16, 8. Read addresses 0x1000, 0x1040, 0x1080; write addresses 0x2000, 0x2040, 0x2080; exactly one DONE at the end.
- WORDS=0 -> DONE 1 cycle after GO, no START, BUSY stays 0.
- BEAT stalled (gaps of 3 cycles) plus spurious BEAT in CORE_RUN -> BUF_PTR steps 0..7 with the gaps, and the spurious BEAT does not change state or pointers.
- ABORT mid-RD_XFER, after beat 3 of 16 -> next cycle IDLE with DMA_RESET=1 and ABORTED=1 for 1 cycle, no DONE. A fresh GO restarts from the new SRC_ADDR.
- Reset asserted mid WR_XFER -> outputs go to their reset values immediately (asynchronously); GO during reset is ignored.
